tlight_ped: RTL and testbench
=============================

# tlight_ped

Pedestrian-signal stage downstream of `tlight`. Consumes the registered vehicle lamp codes `ns`/`we`, latches pedestrian push-button requests, and drives WALK / flashing DON'T-WALK heads for the two crosswalks. It also acts as an independent safety monitor: any conflicting or illegal vehicle lamp code forces both heads to steady DON'T-WALK and raises a sticky fault.

## Interface
- `WALK_TIME`, default 6: cycles of steady WALK.
- `FLASH_TIME`, default 6: cycles of flashing DON'T-WALK after WALK.
- `BLINK_HALF`, default 1: cycles per half-period of the flash.
- Constraint: `WALK_TIME + FLASH_TIME` is less than the `tlight` green length.
- `clock  in  1` — single clock, rising edge.
- `reset_n  in  1` — reset, asynchronous, active-low.
- `ns  in  3` — NS vehicle lamp code from `tlight`.
- `we  in  3` — WE vehicle lamp code from `tlight`.
- `btn_ns  in  1` — push button, NS crosswalk (walks with NS traffic); sync, level or pulse.
- `btn_we  in  1` — push button, WE crosswalk.
- `walk_ns  out  1` — NS WALK lamp.
- `dont_walk_ns  out  1` — NS DON'T-WALK lamp.
- `wait_ns  out  1` — NS request-pending indicator.
- `walk_we  out  1` — WE WALK lamp.
- `dont_walk_we  out  1` — WE DON'T-WALK lamp.
- `wait_we  out  1` — WE request-pending indicator.
- `fault  out  1` — sticky conflict/illegal-code flag.

## Operation
- Lamp codes are one-hot: RED=3'b100, YELLOW=3'b010, GREEN=3'b001.
- Each crosswalk X∈{ns,we} has an independent channel, states P_DONT_WALK, P_WALK, P_FLASH.
- **Request latch:**
  - `btn_X` high in any cycle where the channel is not in P_WALK sets `req_X`.
  - `wait_X` = `req_X`.
  - Cleared on entry to P_WALK.
  - Button in P_WALK is ignored.
- **Green edge:** `grn_X` = (lamp_X==GREEN) && (prev_X!=GREEN), where `prev_X` is a register of the previous lamp_X (reset value RED).
- **P_DONT_WALK → P_WALK** when `grn_X` && (`req_X` || `btn_X` this cycle) && !fault. No request at the edge: no walk this green phase.
- **P_WALK → P_FLASH** after WALK_TIME cycles.
- **P_FLASH → P_DONT_WALK** after FLASH_TIME cycles.
- **Abort:** lamp_X != GREEN while in P_WALK/P_FLASH → P_DONT_WALK next edge. `req_X` is not re-set by the abort.
- **Outputs:**
  - P_WALK: walk=1, dont_walk=0.
  - P_FLASH: walk=0, dont_walk toggles, starting at 1, every BLINK_HALF cycles.
  - P_DONT_WALK: walk=0, dont_walk=1.
- **Fault** sets on any cycle where:
  - `ns` or `we` is not one-hot, or
  - both are non-RED.
- **On fault:**
  - Both channels go to P_DONT_WALK next edge and stay there.
  - Requests are cleared and are not latched.
  - Fault holds until reset.
  - Fault has priority over every other transition.
- All outputs are registered.

## Timing
- **Reset values:**
  - walk_*=0, dont_walk_*=1, wait_*=0, fault=0.
  - state P_DONT_WALK, req=0, prev=RED, counters 0.
- Reset is applied asynchronously, mid-walk included.
- **Latency:**
  - lamp_X becomes GREEN at edge k → `walk_X`=1 from edge k+1.
  - `walk_X` stays 1 for exactly WALK_TIME cycles.
  - Then FLASH_TIME cycles of flash.
  - Then steady `dont_walk_X`.
- `btn_X` sampled at edge j sets `wait_X` from edge j+1.
- `btn_X` in the same cycle as `grn_X` grants the walk; `wait_X` never rises in that case.
- Bad lamp code sampled at edge j gives `fault`=1 and all walk=0, dont_walk=1 from edge j+1.
- Abort: lamp leaves GREEN at edge k → walk=0, dont_walk=1 from edge k+1.
- Counters are sized $clog2(max(WALK_TIME,FLASH_TIME)+1) and never wrap. They reload to 0 on every state entry.

## Structure
- Shared package `tlight_pkg`:
  - lamp constants RED/YELLOW/GREEN.
  - `lamp_t` (logic [2:0]).
  - `ped_state_t` enum.
- `tlight` imports the same package.
- Sub-module `tlight_ped_channel`: request latch, edge detect, FSM, counters, flash. Instantiated twice.
- Top `tlight_ped` holds the fault monitor and the fault broadcast.

## Test plan
- **Reset:** hold reset_n=0 → walk=0, dont_walk=1, wait=0, fault=0. Assert reset_n=0 mid-WALK → same values immediately, without waiting for a clock edge.
- **Normal walk:** pulse `btn_ns` during WE_GO → `wait_ns`=1. Next NS green edge k → `walk_ns`=1 for edges k+1..k+6. Then `dont_walk_ns` = 1,0,1,0,1,0. Then steady 1; `wait_ns`=0.
- **No request:** full `tlight` cycle with no buttons → `walk_*` stays 0 throughout.
- **Edge cases:**
  - `btn_we` in the same cycle as WE green edge → walk granted; `wait_we` never 1.
  - `btn_we` during P_WALK → ignored.
  - `btn_we` during P_FLASH → `wait_we`=1, carried to next WE green.
- **Abort:** drive ns GREEN, then YELLOW 3 cycles into WALK → walk_ns=0, dont_walk_ns=1 the next edge.
- **Fault:** force ns=GREEN, we=GREEN for one cycle → fault=1 next edge and stays 1. Later greens with buttons produce no WALK until reset. Repeat with we=3'b011 → fault.

Source files
------------

// File: rtl/tlight_pkg.sv
// Shared lamp encodings and pedestrian-channel state type for the traffic-light slice.
// Pure declarations; no timing or flow control.
package tlight_pkg;

  typedef logic [2:0] lamp_t;

  localparam lamp_t RED    = 3'b100;
  localparam lamp_t YELLOW = 3'b010;
  localparam lamp_t GREEN  = 3'b001;

  typedef enum logic [1:0] {
    P_DONT_WALK = 2'd0,
    P_WALK      = 2'd1,
    P_FLASH     = 2'd2
  } ped_state_t;

  function automatic logic lamp_legal(input lamp_t l);
    return (l == RED) || (l == YELLOW) || (l == GREEN);
  endfunction

endpackage

// File: rtl/tlight_ped_channel.sv
// One crosswalk: request latch, green-edge detect, WALK/FLASH FSM with blink.
// Lamp-to-walk latency one cycle, all outputs registered; no backpressure.
module tlight_ped_channel
  import tlight_pkg::*;
#(
  parameter int WALK_TIME  = 6,
  parameter int FLASH_TIME = 6,
  parameter int BLINK_HALF = 1
) (
  input  logic  clock,
  input  logic  reset_n,
  input  lamp_t lamp_i,
  input  logic  btn_i,
  input  logic  kill_i,
  output logic  walk_o,
  output logic  dont_walk_o,
  output logic  wait_o
);

  localparam int CNT_MAX = (WALK_TIME > FLASH_TIME) ? WALK_TIME : FLASH_TIME;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  ped_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blink_q, blink_d;
  lamp_t         prev_q;
  logic          req_q, req_d;
  logic          walk_q, walk_d;
  logic          dw_q, dw_d;
  logic          grn, entering;

  assign grn      = (lamp_i == GREEN) && (prev_q != GREEN);
  assign entering = (state_d != state_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= P_DONT_WALK;
      cnt_q   <= '0;
      blink_q <= '0;
      prev_q  <= RED;
      req_q   <= 1'b0;
      walk_q  <= 1'b0;
      dw_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      prev_q  <= lamp_i;
      req_q   <= req_d;
      walk_q  <= walk_d;
      dw_q    <= dw_d;
    end
  end

  // Fault kill outranks the walk grant, the abort and the timers.
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = P_DONT_WALK;
    end else begin
      case (state_q)
        P_DONT_WALK: if (grn && (req_q || btn_i)) state_d = P_WALK;
        P_WALK: begin
          if (lamp_i != GREEN)                    state_d = P_DONT_WALK;
          else if (cnt_q == CW'(WALK_TIME - 1))   state_d = P_FLASH;
        end
        P_FLASH: begin
          if (lamp_i != GREEN)                    state_d = P_DONT_WALK;
          else if (cnt_q == CW'(FLASH_TIME - 1))  state_d = P_DONT_WALK;
        end
        default: state_d = P_DONT_WALK;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    blink_d = '0;
    req_d   = req_q;
    walk_d  = (state_d == P_WALK);
    dw_d    = (state_d != P_WALK);

    if (entering)
      cnt_d = '0;
    else if (state_q != P_DONT_WALK && cnt_q != CW'(CNT_MAX))
      cnt_d = cnt_q + CW'(1);

    if (kill_i)
      req_d = 1'b0;
    else if (entering && state_d == P_WALK)
      req_d = 1'b0;
    else if (btn_i && state_q != P_WALK)
      req_d = 1'b1;

    // Flash phase lives in the dont_walk register itself; first half-period is lit.
    if (state_d == P_FLASH && !entering) begin
      if (blink_q == BW'(BLINK_HALF - 1)) begin
        blink_d = '0;
        dw_d    = ~dw_q;
      end else begin
        blink_d = blink_q + BW'(1);
        dw_d    = dw_q;
      end
    end
  end

  assign walk_o      = walk_q;
  assign dont_walk_o = dw_q;
  assign wait_o      = req_q;

endmodule

// File: rtl/tlight_ped.sv
// Pedestrian heads for both crosswalks plus a sticky lamp-conflict safety monitor.
// Outputs registered, one cycle after the sampled lamp codes; no backpressure.
module tlight_ped
  import tlight_pkg::*;
#(
  parameter int WALK_TIME  = 6,
  parameter int FLASH_TIME = 6,
  parameter int BLINK_HALF = 1
) (
  input  logic  clock,
  input  logic  reset_n,
  input  lamp_t ns,
  input  lamp_t we,
  input  logic  btn_ns,
  input  logic  btn_we,
  output logic  walk_ns,
  output logic  dont_walk_ns,
  output logic  wait_ns,
  output logic  walk_we,
  output logic  dont_walk_we,
  output logic  wait_we,
  output logic  fault
);

  logic fault_q, bad, kill;

  // Kill uses the live violation too, so the bad cycle itself already blocks a grant.
  assign bad  = !lamp_legal(ns) || !lamp_legal(we) || (ns != RED && we != RED);
  assign kill = bad || fault_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= fault_q | bad;
  end

  assign fault = fault_q;

  tlight_ped_channel #(
    .WALK_TIME (WALK_TIME),
    .FLASH_TIME(FLASH_TIME),
    .BLINK_HALF(BLINK_HALF)
  ) u_ns (
    .clock      (clock),
    .reset_n    (reset_n),
    .lamp_i     (ns),
    .btn_i      (btn_ns),
    .kill_i     (kill),
    .walk_o     (walk_ns),
    .dont_walk_o(dont_walk_ns),
    .wait_o     (wait_ns)
  );

  tlight_ped_channel #(
    .WALK_TIME (WALK_TIME),
    .FLASH_TIME(FLASH_TIME),
    .BLINK_HALF(BLINK_HALF)
  ) u_we (
    .clock      (clock),
    .reset_n    (reset_n),
    .lamp_i     (we),
    .btn_i      (btn_we),
    .kill_i     (kill),
    .walk_o     (walk_we),
    .dont_walk_o(dont_walk_we),
    .wait_o     (wait_we)
  );

endmodule

// File: tb/tb_tlight_ped.sv
// Directed-vector bench for tlight_ped: driver queues expected outputs, monitor compares each cycle.
module tb_tlight_ped;
  import tlight_pkg::*;

  logic  clock = 1'b0;
  logic  reset_n;
  lamp_t ns, we;
  logic  btn_ns, btn_we;
  logic  walk_ns, dont_walk_ns, wait_ns, walk_we, dont_walk_we, wait_we, fault;

  // Expected vector layout: {walk_ns, dont_walk_ns, wait_ns, walk_we, dont_walk_we, wait_we, fault}
  localparam logic [6:0] IDLE   = 7'b0100100;
  localparam logic [6:0] WAITN  = 7'b0110100;
  localparam logic [6:0] WN     = 7'b1000100;
  localparam logic [6:0] FLN0   = 7'b0000100;
  localparam logic [6:0] WW     = 7'b0101000;
  localparam logic [6:0] WAITW  = 7'b0100110;
  localparam logic [6:0] FLW0_Q = 7'b0100010;
  localparam logic [6:0] BOTHQ  = 7'b0110110;
  localparam logic [6:0] FLT    = 7'b0100101;

  typedef struct {
    logic [6:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic [6:0] got;

  assign got = {walk_ns, dont_walk_ns, wait_ns, walk_we, dont_walk_we, wait_we, fault};

  tlight_ped dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ns          (ns),
    .we          (we),
    .btn_ns      (btn_ns),
    .btn_we      (btn_we),
    .walk_ns     (walk_ns),
    .dont_walk_ns(dont_walk_ns),
    .wait_ns     (wait_ns),
    .walk_we     (walk_we),
    .dont_walk_we(dont_walk_we),
    .wait_we     (wait_we),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got=%b", got);
    $fatal(1, "timeout");
  end

  always @(posedge clock) begin : monitor
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (got !== e.v) begin
        fails++;
        $display("FAIL %s: got %b expected %b (t=%0t)", e.nm, got, e.v, $time);
      end
    end
  end

  task automatic cyc(input lamp_t n, input lamp_t w, input logic bn, input logic bw,
                     input logic [6:0] e, input string nm);
    exp_t x;
    @(negedge clock);
    ns = n; we = w; btn_ns = bn; btn_we = bw;
    x.v = e; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic check_now(input logic [6:0] e, input string nm);
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, e, $time);
    end
  endtask

  initial begin
    reset_n = 1'b0; ns = RED; we = RED; btn_ns = 1'b0; btn_we = 1'b0;
    #12;
    check_now(IDLE, "reset_hold");
    @(negedge clock) reset_n = 1'b1;

    // Normal NS walk requested during WE green
    cyc(RED, GREEN, 0, 0, IDLE,  "we_go_no_req");
    cyc(RED, GREEN, 1, 0, WAITN, "btn_ns_sets_wait");
    cyc(RED, GREEN, 0, 0, WAITN, "wait_ns_holds");
    cyc(RED, YELLOW, 0, 0, WAITN, "wait_ns_yellow");
    cyc(RED, RED, 0, 0, WAITN, "wait_ns_allred");
    for (int i = 0; i < 6; i++) cyc(GREEN, RED, 0, 0, WN, "ns_walk");
    for (int i = 0; i < 6; i++) cyc(GREEN, RED, 0, 0, (i % 2 == 0) ? IDLE : FLN0, "ns_flash");
    cyc(GREEN, RED, 0, 0, IDLE, "ns_steady_dw");
    cyc(GREEN, RED, 0, 0, IDLE, "ns_steady_dw2");
    cyc(YELLOW, RED, 0, 0, IDLE, "ns_yellow");
    cyc(RED, RED, 0, 0, IDLE, "allred");

    // WE: button on the green edge, in WALK (ignored), in FLASH (carried)
    cyc(RED, GREEN, 0, 1, WW, "we_btn_on_green_edge");
    cyc(RED, GREEN, 0, 1, WW, "we_btn_in_walk_ignored");
    for (int i = 0; i < 4; i++) cyc(RED, GREEN, 0, 0, WW, "we_walk");
    cyc(RED, GREEN, 0, 0, IDLE,   "we_flash_on");
    cyc(RED, GREEN, 0, 1, FLW0_Q, "we_btn_in_flash");
    cyc(RED, GREEN, 0, 0, WAITW,  "we_flash_on_q");
    cyc(RED, GREEN, 0, 0, FLW0_Q, "we_flash_off_q");
    cyc(RED, GREEN, 0, 0, WAITW,  "we_flash_on_q2");
    cyc(RED, GREEN, 0, 0, FLW0_Q, "we_flash_off_q2");
    cyc(RED, GREEN, 0, 0, WAITW,  "we_flash_done");
    cyc(RED, YELLOW, 0, 0, WAITW, "we_yellow_q");
    cyc(RED, RED, 0, 0, WAITW, "allred_q");
    for (int i = 0; i < 3; i++) cyc(GREEN, RED, 0, 0, WAITW, "ns_green_no_req");
    cyc(YELLOW, RED, 0, 0, WAITW, "ns_yellow_q");
    cyc(RED, RED, 0, 0, WAITW, "allred_q2");
    cyc(RED, GREEN, 0, 0, WW, "we_carried_req_walk");
    cyc(RED, GREEN, 0, 0, WW, "we_walk2");
    cyc(RED, YELLOW, 0, 0, IDLE, "we_abort");
    cyc(RED, RED, 0, 0, IDLE, "allred3");

    // Full cycle with no buttons
    for (int i = 0; i < 3; i++) cyc(GREEN, RED, 0, 0, IDLE, "no_req_ns");
    cyc(YELLOW, RED, 0, 0, IDLE, "no_req_ns_y");
    cyc(RED, RED, 0, 0, IDLE, "no_req_rr");
    for (int i = 0; i < 3; i++) cyc(RED, GREEN, 0, 0, IDLE, "no_req_we");
    cyc(RED, YELLOW, 0, 0, IDLE, "no_req_we_y");
    cyc(RED, RED, 0, 0, IDLE, "no_req_rr2");

    // NS abort three cycles into WALK
    cyc(RED, RED, 1, 0, WAITN, "ns_req_abort");
    for (int i = 0; i < 3; i++) cyc(GREEN, RED, 0, 0, WN, "ns_walk_pre_abort");
    cyc(YELLOW, RED, 0, 0, IDLE, "ns_abort");
    cyc(RED, RED, 0, 0, IDLE, "ns_abort_rr");

    // Fault: both green with pending requests
    cyc(RED, RED, 1, 1, BOTHQ, "reqs_before_fault");
    cyc(GREEN, GREEN, 0, 0, FLT, "fault_both_green");
    cyc(RED, RED, 1, 1, FLT, "fault_sticky_no_latch");
    for (int i = 0; i < 3; i++) cyc(GREEN, RED, 1, 0, FLT, "fault_ns_green_btn");
    cyc(YELLOW, RED, 0, 0, FLT, "fault_ns_yellow");
    cyc(RED, RED, 0, 0, FLT, "fault_rr");
    cyc(RED, GREEN, 0, 1, FLT, "fault_we_green_btn");
    cyc(RED, GREEN, 0, 0, FLT, "fault_we_green2");

    @(negedge clock);
    reset_n = 1'b0; ns = RED; we = RED; btn_ns = 1'b0; btn_we = 1'b0;
    #1;
    check_now(IDLE, "reset_clears_fault");
    @(negedge clock) reset_n = 1'b1;

    // Asynchronous reset in the middle of WALK
    cyc(RED, RED, 1, 0, WAITN, "ns_req_rst");
    for (int i = 0; i < 3; i++) cyc(GREEN, RED, 0, 0, WN, "ns_walk_pre_rst");
    @(posedge clock);
    #3;
    reset_n = 1'b0; ns = RED; we = RED;
    #1;
    check_now(IDLE, "async_reset_mid_walk");
    @(negedge clock) reset_n = 1'b1;

    // Illegal code on WE
    cyc(RED, RED, 0, 0, IDLE, "post_reset_idle");
    cyc(RED, 3'b011, 0, 0, FLT, "fault_illegal_we");
    cyc(RED, RED, 1, 1, FLT, "fault2_no_latch");
    cyc(GREEN, RED, 1, 0, FLT, "fault2_ns_green");

    repeat (3) @(negedge clock);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
